systolic_seq: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_seq_if.sv | 36 +++
 rtl/systolic_seq_skew_mux.sv | 22 ++
 rtl/systolic_seq.sv | 145 ++++++++++++++
 tb/tb_systolic_seq.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: minifloat layout and FSM states.
package systolic_pkg;

  localparam int DW       = 8;
  localparam int SIGN_B   = 7;
  localparam int EXP_HI   = 6;
  localparam int EXP_LO   = 4;
  localparam int FRAC_HI  = 3;
  localparam int EXP_BIAS = 3;

  localparam logic [DW-1:0] MF_ZERO = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/systolic_seq_if.sv
// Host load / array feed bundle for systolic_seq; master = host side, slave = sequencer.
interface systolic_seq_if
  import systolic_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = $clog2(N*N)
) ();

  // wr_en and start are single-cycle qualifiers with no back-pressure: they take
  // effect only while the sequencer is in IDLE (dbg_state == IDLE) and are dropped
  // otherwise. Outputs are registered; feed_valid qualifies a_row/b_col.
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            acc_clr;
  logic            feed_valid;
  logic [N*DW-1:0] a_row;
  logic [N*DW-1:0] b_col;
  seq_state_t      dbg_state;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, acc_clr, feed_valid, a_row, b_col, dbg_state
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, acc_clr, feed_valid, a_row, b_col, dbg_state
  );

endinterface

// File: rtl/systolic_seq_skew_mux.sv
// Picks element (t - IDX) of one buffer row/column, or zero when outside the skew window.
module skew_mux
  import systolic_pkg::*;
#(
  parameter int N   = 3,
  parameter int EW  = 8,
  parameter int TW  = 3,
  parameter int IDX = 0
) (
  input  logic [TW-1:0]        t,
  input  logic [N-1:0][EW-1:0] line,
  output logic [EW-1:0]        elem
);

  always_comb begin
    elem = EW'(MF_ZERO);
    for (int m = 0; m < N; m++) begin
      if (int'(t) == IDX + m) elem = line[m];
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for an N x N systolic MAC array: holds A/B, clears accumulators, streams skewed operands.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  systolic_seq_if.slave bus
);

  localparam int NE     = N * N;
  localparam int LAST_T = 3 * N - 3;
  localparam int TW     = $clog2(3 * N - 2);

  seq_state_t      state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            acc_clr_q, acc_clr_d;
  logic            feed_valid_q, feed_valid_d;
  logic [N*DW-1:0] a_row_q, a_row_d;
  logic [N*DW-1:0] b_col_q, b_col_d;
  logic [DW-1:0]   a_buf_q [NE];
  logic [DW-1:0]   a_buf_d [NE];
  logic [DW-1:0]   b_buf_q [NE];
  logic [DW-1:0]   b_buf_d [NE];

  logic [N-1:0][DW-1:0] a_line [N];
  logic [N-1:0][DW-1:0] b_line [N];
  logic [DW-1:0]        a_elem [N];
  logic [DW-1:0]        b_elem [N];

  // Row r of A and column r of B; muxes are indexed by the t of the cycle being loaded.
  for (genvar r = 0; r < N; r++) begin : g_lane
    for (genvar c = 0; c < N; c++) begin : g_elem
      assign a_line[r][c] = a_buf_q[r*N + c];
      assign b_line[r][c] = b_buf_q[c*N + r];
    end
    skew_mux #(.N(N), .EW(DW), .TW(TW), .IDX(r)) u_skew_a (
      .t(t_d), .line(a_line[r]), .elem(a_elem[r])
    );
    skew_mux #(.N(N), .EW(DW), .TW(TW), .IDX(r)) u_skew_b (
      .t(t_d), .line(b_line[r]), .elem(b_elem[r])
    );
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == TW'(LAST_T)) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffers only change in IDLE, so a same-cycle write lands before the run reads it.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (state_q == IDLE && bus.wr_en && (int'(bus.wr_addr) < NE)) begin
      if (bus.wr_sel) b_buf_d[bus.wr_addr] = bus.wr_data;
      else            a_buf_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    acc_clr_d    = 1'b0;
    feed_valid_d = 1'b0;
    a_row_d      = '0;
    b_col_d      = '0;
    case (state_d)
      CLEAR: begin
        acc_clr_d = 1'b1;
        busy_d    = 1'b1;
      end
      FEED: begin
        feed_valid_d = 1'b1;
        busy_d       = 1'b1;
        for (int g = 0; g < N; g++) begin
          a_row_d[g*DW +: DW] = a_elem[g];
          b_col_d[g*DW +: DW] = b_elem[g];
        end
      end
      DRAIN:   busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      t_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      feed_valid_q <= 1'b0;
      a_row_q      <= '0;
      b_col_q      <= '0;
      for (int e = 0; e < NE; e++) begin
        a_buf_q[e] <= DW'(MF_ZERO);
        b_buf_q[e] <= DW'(MF_ZERO);
      end
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      acc_clr_q    <= acc_clr_d;
      feed_valid_q <= feed_valid_d;
      a_row_q      <= a_row_d;
      b_col_q      <= b_col_d;
      a_buf_q      <= a_buf_d;
      b_buf_q      <= b_buf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.feed_valid = feed_valid_q;
  assign bus.a_row      = a_row_q;
  assign bus.b_col      = b_col_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: reference matrices, skew model, and a minifloat MAC array model.
module tb_systolic_seq;
  import systolic_pkg::*;

  localparam int N        = 3;
  localparam int AW       = $clog2(N*N);
  localparam int NE       = N * N;
  localparam int FEED_LEN = 3 * N - 2;
  localparam int RUN_LEN  = 3 * N + 2;
  localparam int VW       = 2 * N * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  systolic_seq_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  systolic_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference state ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_a [NE];
  logic [DW-1:0] ref_b [NE];
  logic [VW-1:0] exp_q [$];

  real           mac_acc [N][N];
  logic [DW-1:0] a_pipe  [N][N];
  logic [DW-1:0] b_pipe  [N][N];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_real(input string name, input int idx, input real act, input real exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %f expected %f", name, idx, act, exp);
    end
  endtask

  function automatic real mf_to_real(input logic [DW-1:0] v);
    real m;
    int  e;
    if (v == MF_ZERO) return 0.0;
    m = 1.0 + real'(int'(v[FRAC_HI:0])) / 16.0;
    e = int'(v[EXP_HI:EXP_LO]) - EXP_BIAS;
    for (int s = 0; s < e; s++) m = m * 2.0;
    for (int s = 0; s < -e; s++) m = m / 2.0;
    return v[SIGN_B] ? -m : m;
  endfunction

  function automatic logic [DW-1:0] real_to_mf(input real x);
    real m;
    int  e, f, eb;
    logic [DW-1:0] r;
    if (x == 0.0) return MF_ZERO;
    m = (x < 0.0) ? -x : x;
    e = 0;
    for (int s = 0; s < 16; s++) if (m >= 2.0) begin m = m / 2.0; e++; end
    for (int s = 0; s < 16; s++) if (m < 1.0) begin m = m * 2.0; e--; end
    f  = int'($floor((m - 1.0) * 16.0));
    if (f > 15) f = 15;
    eb = e + EXP_BIAS;
    if (eb < 0) eb = 0;
    if (eb > 7) eb = 7;
    r = '0;
    r[SIGN_B]        = (x < 0.0);
    r[EXP_HI:EXP_LO] = 3'(eb);
    r[FRAC_HI:0]     = 4'(f);
    return r;
  endfunction

  // Operand pair seen at array edges in feed cycle t, straight from the matrices.
  function automatic logic [VW-1:0] feed_vec(input int t);
    logic [N*DW-1:0] a, b;
    int k;
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      k = t - i;
      if (k >= 0 && k < N) begin
        a[i*DW +: DW] = ref_a[i*N + k];
        b[i*DW +: DW] = ref_b[k*N + i];
      end
    end
    return {a, b};
  endfunction

  function automatic logic [3:0] flags_at(input int c);
    // {acc_clr, feed_valid, busy, done} in cycle c after start was sampled
    return {c == 1, (c >= 2 && c <= 3*N-1), (c >= 1 && c <= 3*N), c == 3*N+1};
  endfunction

  task automatic ref_write(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (int'(addr) < NE) begin
      if (sel) ref_b[addr] = data;
      else     ref_a[addr] = data;
    end
  endtask

  task automatic ref_clear();
    for (int e = 0; e < NE; e++) begin
      ref_a[e] = MF_ZERO;
      ref_b[e] = MF_ZERO;
    end
  endtask

  task automatic push_run();
    for (int t = 0; t < FEED_LEN; t++) exp_q.push_back(feed_vec(t));
  endtask

  // ---------------- MAC array model ----------------
  always @(posedge clk) begin
    logic [DW-1:0] a_in, b_in;
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mac_acc[i][j] <= 0.0;
          a_pipe[i][j]  <= MF_ZERO;
          b_pipe[i][j]  <= MF_ZERO;
        end
    end else if (bus.acc_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) mac_acc[i][j] <= 0.0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) a_in = bus.a_row[i*DW +: DW];
          else        a_in = a_pipe[i][j-1];
          if (i == 0) b_in = bus.b_col[j*DW +: DW];
          else        b_in = b_pipe[i-1][j];
          mac_acc[i][j] <= mac_acc[i][j] + mf_to_real(a_in) * mf_to_real(b_in);
          a_pipe[i][j]  <= a_in;
          b_pipe[i][j]  <= b_in;
        end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int mon_t = 0;
  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (bus.feed_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL feed_unexpected[%0d]: got %0h expected no feed", mon_t, {bus.a_row, bus.b_col});
      end else begin
        e = exp_q.pop_front();
        check("feed_t", mon_t, 64'({bus.a_row, bus.b_col}), 64'(e));
      end
      mon_t++;
    end else begin
      mon_t = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_elem(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    ref_write(sel, addr, data);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_run(input bit coll, input logic c_sel, input logic [AW-1:0] c_addr,
                        input logic [DW-1:0] c_data, input bit lock_wr, input bit hold,
                        input int abort_c);
    int   len;
    logic [3:0] exp_f;
    bit   done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    if (coll) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = c_sel;
      bus.wr_addr = c_addr;
      bus.wr_data = c_data;
      ref_write(c_sel, c_addr, c_data);
    end
    push_run();
    if (hold) push_run();
    len = hold ? 2*RUN_LEN + 1 : RUN_LEN;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (abort_c != 0 && c == abort_c + 1) begin
        check("abort_outputs", c, 64'({bus.busy, bus.done, bus.feed_valid, bus.a_row, bus.b_col}), 64'(0));
        check("abort_state", c, 64'(bus.dbg_state), 64'(IDLE));
        exp_q.delete();
        ref_clear();
        rst_n = 1'b1;
        break;
      end
      exp_f = flags_at(c);
      if (hold) exp_f = exp_f | flags_at(c - RUN_LEN);
      check("flags", c, 64'({bus.acc_clr, bus.feed_valid, bus.busy, bus.done}), 64'(exp_f));
      if (abort_c == 0 && (c == RUN_LEN || c == len))
        check("idle_state", c, 64'(bus.dbg_state), 64'(IDLE));
      if (c == 1) begin
        bus.wr_en = 1'b0;
        if (!hold) bus.start = 1'b0;
      end
      if (hold && c == RUN_LEN + 1) bus.start = 1'b0;
      if (lock_wr && c == 4) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 8'h7F;
      end
      if (c == 5) bus.wr_en = 1'b0;
      if (abort_c != 0 && c == abort_c) rst_n = 1'b0;
    end
    if (abort_c != 0) begin
      done_seen = 1'b0;
      for (int c = 0; c < RUN_LEN; c++) begin
        @(negedge clk);
        done_seen = done_seen | bus.done;
      end
      check("abort_no_done", 0, 64'(done_seen), 64'(0));
    end
  endtask

  task automatic check_matmul();
    real cexp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cexp = 0.0;
        for (int k = 0; k < N; k++) cexp = cexp + mf_to_real(ref_a[i*N+k]) * mf_to_real(ref_b[k*N+j]);
        check_real("matmul", i*N + j, mac_acc[i][j], cexp);
      end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    ref_clear();
    repeat (3) @(negedge clk);
    check("reset_outputs", 0,
          64'({bus.busy, bus.done, bus.acc_clr, bus.feed_valid, bus.a_row, bus.b_col}), 64'(0));
    check("reset_state", 0, 64'(bus.dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    // Skew pattern
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        write_elem(1'b0, AW'(i*N + k), DW'(8'h10 * (i + 1) + k));
        write_elem(1'b1, AW'(k*N + i), DW'(8'h40 + 4*k + i));
      end
    do_run(0, 0, '0, '0, 0, 0, 0);
    check_matmul();

    // Write lockout during FEED, then a re-run with the original A
    do_run(0, 0, '0, '0, 1, 0, 0);
    do_run(0, 0, '0, '0, 0, 0, 0);

    // Start collides with a write
    do_run(1, 1'b0, AW'(4), 8'h38, 0, 0, 0);

    // Out-of-range writes are dropped
    write_elem(1'b0, AW'(9), 8'hFF);
    write_elem(1'b1, AW'(15), 8'hEE);
    do_run(0, 0, '0, '0, 0, 0, 0);

    // Reset in FEED t=3, then a run over the cleared buffers
    do_run(0, 0, '0, '0, 0, 0, 5);
    do_run(0, 0, '0, '0, 0, 0, 0);

    // Identity x identity through the MAC array model
    for (int d = 0; d < N; d++) begin
      write_elem(1'b0, AW'(d*N + d), 8'h30);
      write_elem(1'b1, AW'(d*N + d), 8'h30);
    end
    do_run(0, 0, '0, '0, 0, 0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check("identity_cell", i*N + j, 64'(real_to_mf(mac_acc[i][j])), 64'((i == j) ? 8'h30 : 8'h00));

    // Random matrices; the middle one holds start high for a back-to-back run
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < NE; e++) begin
        write_elem(1'b0, AW'(e), ($urandom_range(0, 3) == 0) ? MF_ZERO : DW'($urandom_range(0, 255)));
        write_elem(1'b1, AW'(e), ($urandom_range(0, 3) == 0) ? MF_ZERO : DW'($urandom_range(0, 255)));
      end
      do_run(0, 0, '0, '0, 0, (r == 1), 0);
      check_matmul();
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 0, 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
